// File: rtl/bconv_layer_streamer_if.sv
// Byte-stream interface between the layer streamer and its consumer.
// Handshake: the producer holds data_o/last_o stable while valid_o=1 and
// ready_i=0; a byte moves on any rising edge where valid_o=1 and ready_i=1.
interface bconv_layer_streamer_if #(
   parameter int BYTE_W = 8
) ();
   logic [BYTE_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;
   logic              last_o;

   modport master (output data_o, output valid_o, output last_o, input ready_i);
   modport slave  (input data_o, input valid_o, input last_o, output ready_i);
endinterface

// File: rtl/bconv_layer_streamer.sv
// Captures a DIM x DIM binary feature map on start_i and streams it out
// byte by byte (row-major bit order, LSB first) over a valid/ready bus.
module bconv_layer_streamer #(
   parameter int DIM    = 26,
   parameter int BYTE_W = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_i,
   input  logic [DIM-1:0][DIM-1:0]   layer_i,
   bconv_layer_streamer_if.master    m_if,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [1:0]                dbg_state_o
);
   localparam int NBITS  = DIM * DIM;
   localparam int NBYTES = (NBITS + BYTE_W - 1) / BYTE_W;
   localparam int CNT_W  = $clog2(NBYTES);
   localparam int PAD_W  = NBYTES * BYTE_W;
   localparam int IDX_W  = $clog2(PAD_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [NBITS-1:0]  r_snap;
   logic [CNT_W-1:0]  r_cnt;
   logic [PAD_W-1:0]  w_pad;
   logic [IDX_W-1:0]  w_base;
   logic              w_valid;
   logic              w_last_cnt;
   logic              w_xfer;
   logic              w_capture;

   assign w_last_cnt = (r_cnt == CNT_W'(NBYTES - 1));
   assign w_xfer     = w_valid & m_if.ready_i;
   assign w_capture  = (r_state == ST_IDLE) & start_i;
   assign w_base     = IDX_W'(r_cnt) * IDX_W'(BYTE_W);

   // Zero-extend the snapshot so the tail byte reads 0 beyond NBITS.
   always_comb begin
      w_pad              = '0;
      w_pad[NBITS-1:0]   = r_snap;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and valid decode; start_i only matters in IDLE.
   always_comb begin
      w_next  = r_state;
      w_valid = 1'b0;
      case (r_state)
         ST_IDLE: if (start_i) w_next = ST_SEND;
         ST_SEND: begin
            w_valid = 1'b1;
            if (m_if.ready_i && w_last_cnt) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Snapshot on capture; byte counter advances per transfer and parks at the
   // final index so it never exceeds NBYTES-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_snap <= '0;
         r_cnt  <= '0;
      end else if (w_capture) begin
         r_snap <= layer_i;
         r_cnt  <= '0;
      end else if (w_xfer && !w_last_cnt) begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign m_if.valid_o = w_valid;
   assign m_if.data_o  = w_valid ? w_pad[w_base +: BYTE_W] : '0;
   assign m_if.last_o  = w_valid & w_last_cnt;
   assign busy_o       = (r_state != ST_IDLE);
   assign done_o       = (r_state == ST_DONE);
   assign dbg_state_o  = r_state;
endmodule

// File: tb/tb_bconv_layer_streamer.sv
// Directed + randomized bench for bconv_layer_streamer with a bit-level
// reference model and an expected-byte queue.
module tb_bconv_layer_streamer;
  localparam int DIM    = 26;
  localparam int NBITS  = DIM * DIM;
  localparam int NBYTES = (NBITS + 7) / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                    start_i = 1'b0;
  logic [DIM-1:0][DIM-1:0] layer_i = '0;
  logic                    busy_o, done_o;
  logic [1:0]              dbg_state_o;

  bconv_layer_streamer_if #(.BYTE_W(8)) s_if ();

  bconv_layer_streamer #(.DIM(DIM), .BYTE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .layer_i(layer_i),
    .m_if(s_if), .busy_o(busy_o), .done_o(done_o), .dbg_state_o(dbg_state_o)
  );

  int errors = 0;
  int checks = 0;
  bit lay [DIM][DIM];
  logic [7:0] exp_q [$];
  logic [7:0] got [NBYTES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte n holds bits k=8n..8n+7 of the row-major map, LSB first.
  task automatic build_expected();
    exp_q.delete();
    for (int n = 0; n < NBYTES; n++) begin
      logic [7:0] b;
      b = '0;
      for (int j = 0; j < 8; j++) begin
        int k;
        k = 8 * n + j;
        if (k < NBITS) b[j] = lay[k / DIM][k % DIM];
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_layer();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        layer_i[r][c] = lay[r][c];
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(s_if.valid_o), 32'd0);
    chk({tag, "_data"},  32'(s_if.data_o),  32'd0);
    chk({tag, "_last"},  32'(s_if.last_o),  32'd0);
    chk({tag, "_busy"},  32'(busy_o),       32'd0);
    chk({tag, "_done"},  32'(done_o),       32'd0);
  endtask

  // Driver + monitor for one frame; called at a negedge. abort_at>=0 asserts
  // rst_n when that many bytes have been transferred.
  task automatic run_frame(input int stall_pct, input bit disturb,
                           input int abort_at, output bit aborted);
    int sent = 0;
    int cyc = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0;
    aborted = 0;
    build_expected();
    drive_layer();
    start_i = 1'b1;
    s_if.ready_i = 1'b0;
    @(negedge clk);
    cyc = 1;
    start_i = 1'b0;
    while (sent < NBYTES && cyc < 4000) begin
      chk("valid_in_send", 32'(s_if.valid_o), 32'd1);
      chk("busy_in_send",  32'(busy_o),       32'd1);
      if (prev_stall) begin
        chk("stall_data_stable", 32'(s_if.data_o), 32'(prev_d));
        chk("stall_last_stable", 32'(s_if.last_o), 32'(prev_l));
      end
      chk("data_byte", 32'(s_if.data_o), 32'(exp_q[0]));
      chk("last_flag", 32'(s_if.last_o), 32'(sent == NBYTES - 1));
      if (abort_at >= 0 && sent == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        aborted = 1;
        return;
      end
      if (disturb && cyc == 5) begin
        start_i = 1'b1;
        layer_i = ~layer_i;
      end else begin
        start_i = 1'b0;
      end
      s_if.ready_i = ($urandom_range(99) >= stall_pct);
      prev_d = s_if.data_o;
      prev_l = s_if.last_o;
      if (s_if.ready_i) begin
        got[sent] = exp_q.pop_front();
        got[sent] = s_if.data_o;
        sent++;
        prev_stall = 0;
      end else begin
        prev_stall = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0;
    s_if.ready_i = 1'b0;
    chk("transfer_count", 32'(sent), 32'(NBYTES));
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_busy",  32'(busy_o), 32'd1);
    chk("done_valid", 32'(s_if.valid_o), 32'd0);
    chk("done_data",  32'(s_if.data_o), 32'd0);
    if (stall_pct == 0) chk("done_latency", 32'(cyc), 32'(NBYTES + 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_outputs("post_frame_idle");
    end
  endtask

  initial begin
    bit ab;
    s_if.ready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;

    // all ones
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = 1'b1;
    run_frame(0, 0, -1, ab);
    chk("ones_byte0",  32'(got[0]),  32'hFF);
    chk("ones_byte83", 32'(got[83]), 32'hFF);
    chk("ones_byte84", 32'(got[84]), 32'h0F);

    // odd columns set
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = c[0];
    run_frame(0, 0, -1, ab);
    chk("odd_byte0",  32'(got[0]),  32'hAA);
    chk("odd_byte84", 32'(got[84]), 32'h0A);

    // two corners only
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = 1'b0;
    lay[0][0] = 1'b1;
    lay[DIM-1][DIM-1] = 1'b1;
    run_frame(0, 0, -1, ab);
    chk("corner_byte0",  32'(got[0]),  32'h01);
    chk("corner_byte42", 32'(got[42]), 32'h00);
    chk("corner_byte84", 32'(got[84]), 32'h08);

    // random map, ~50% backpressure
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = $urandom_range(1);
    run_frame(50, 0, -1, ab);

    // random map, restart attempt and layer change mid-frame
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = $urandom_range(1);
    run_frame(30, 1, -1, ab);

    // reset at byte 40, then a fresh frame right after release
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = $urandom_range(1);
    run_frame(0, 0, 40, ab);
    chk("abort_taken", 32'(ab), 32'd1);
    s_if.ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("after_release");
    for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) lay[r][c] = $urandom_range(1);
    run_frame(50, 0, -1, ab);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
